// File: rtl/mod_arith_pkg.sv
// Shared definitions for the modular-arithmetic sequencer.
// Contents: CU op encodings, program entry field positions, sequencer error
// codes and the sequencer state encoding.
package mod_arith_pkg;

    typedef enum logic [2:0] {
        X_MUL_Y = 3'd0,
        X_SQR_X = 3'd1,
        X_INV_X = 3'd2,
        X_MOV_Y = 3'd3,
        X_ADD_Y = 3'd4,
        X_SUB_Y = 3'd5,
        X_NEG_X = 3'd6,
        X_RTB   = 3'd7
    } cu_op_t;

    // Program entry layout: [7]=end [6]=accy [5]=accx [4]=mod [3]=reserved [2:0]=op
    localparam int unsigned END_B  = 7;
    localparam int unsigned ACCY_B = 6;
    localparam int unsigned ACCX_B = 5;
    localparam int unsigned MOD_B  = 4;
    localparam int unsigned RSVD_B = 3;
    localparam int unsigned OP_LSB = 0;
    localparam int unsigned OP_W   = 3;

    localparam logic [1:0] ERR_OK    = 2'd0;
    localparam logic [1:0] ERR_TO    = 2'd1;
    localparam logic [1:0] ERR_ABORT = 2'd2;
    localparam logic [1:0] ERR_OVR   = 2'd3;

    typedef enum logic [6:0] {
        S_IDLE  = 7'b000_0001,
        S_FETCH = 7'b000_0010,
        S_ISSUE = 7'b000_0100,
        S_WAIT  = 7'b000_1000,
        S_ABORT = 7'b001_0000,
        S_DRAIN = 7'b010_0000,
        S_DONE  = 7'b100_0000
    } seq_state_t;

endpackage

// File: rtl/mod_arith_seq_ram.sv
// Program store: DEPTH x 8, one write port, one synchronous read port.
// Contents are not reset. Written to map onto distributed or block RAM.
// Ports:
//   clk          clock
//   we           write strobe
//   waddr/wdata  write address / entry
//   raddr        read address, sampled on clk
//   rdata        entry at raddr from the previous clock edge
module mod_arith_seq_ram
    import mod_arith_pkg::*;
#(
    parameter int unsigned DEPTH = 32,
    parameter int unsigned AW    = 5
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/mod_arith_seq.sv
// Microprogram sequencer feeding the modular-arithmetic control unit (CU).
// Issues stored commands one at a time on the CU op/en/ready handshake,
// supervises each with a watchdog and supports host abort via CU clear.
// Ports:
//   clk, rst_n             clock, async active-low reset
//   prog_we/addr/data      program write port (ignored while busy)
//   start, start_addr      launch a program at start_addr
//   abort                  cancel the running program
//   busy, done, err_code   run status; err_code held until next start
//   pc                     address of the current entry
//   cu_op, cu_en, cu_opt_* command interface to the CU
//   cu_clear               CU clear pulse on timeout/abort
//   cu_ready               CU idle indication
module mod_arith_seq
    import mod_arith_pkg::*;
#(
    parameter int unsigned DEPTH   = 32,
    parameter int unsigned AW      = 5,
    parameter int unsigned TO_W    = 10,
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  logic [7:0]    prog_data,
    input  logic          start,
    input  logic [AW-1:0] start_addr,
    input  logic          abort,
    output logic          busy,
    output logic          done,
    output logic [1:0]    err_code,
    output logic [AW-1:0] pc,
    output logic [2:0]    cu_op,
    output logic          cu_en,
    output logic          cu_opt_mod,
    output logic          cu_opt_accx,
    output logic          cu_opt_accy,
    output logic          cu_clear,
    input  logic          cu_ready
);

    seq_state_t      state, state_d;
    logic [AW-1:0]   pc_d;
    logic [7:0]      ir, ir_d;
    logic [7:0]      rdata;
    logic [1:0]      err_d;
    logic [TO_W-1:0] wd, wd_d;
    logic            ir_rsvd_unused;

    // The RAM is addressed with the next pc so the entry is already on rdata
    // during FETCH and ir loads at the end of that single cycle.
    mod_arith_seq_ram #(
        .DEPTH(DEPTH),
        .AW   (AW)
    ) u_ram (
        .clk  (clk),
        .we   (prog_we & ~busy),
        .waddr(prog_addr),
        .wdata(prog_data),
        .raddr(pc_d),
        .rdata(rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            pc       <= '0;
            ir       <= '0;
            err_code <= ERR_OK;
            wd       <= '0;
        end else begin
            state    <= state_d;
            pc       <= pc_d;
            ir       <= ir_d;
            err_code <= err_d;
            wd       <= wd_d;
        end
    end

    always_comb begin
        state_d = state;
        pc_d    = pc;
        ir_d    = ir;
        err_d   = err_code;
        wd_d    = wd;
        unique case (state)
            S_IDLE: begin
                if (start && !abort) begin
                    pc_d    = start_addr;
                    err_d   = ERR_OK;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                if (abort) begin
                    err_d   = ERR_ABORT;
                    state_d = S_ABORT;
                end else begin
                    ir_d    = rdata;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (abort) begin
                    err_d   = ERR_ABORT;
                    state_d = S_ABORT;
                end else if (cu_ready) begin
                    wd_d    = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (abort) begin
                    err_d   = ERR_ABORT;
                    state_d = S_ABORT;
                end else if (cu_ready) begin
                    if (ir[END_B]) begin
                        state_d = S_DONE;
                    end else if (pc == AW'(DEPTH - 1)) begin
                        err_d   = ERR_OVR;
                        state_d = S_DONE;
                    end else begin
                        pc_d    = pc + AW'(1);
                        state_d = S_FETCH;
                    end
                end else begin
                    // Leaves WAIT on the cycle the count reaches TIMEOUT,
                    // so at most TIMEOUT cycles are spent waiting.
                    wd_d = wd + TO_W'(1);
                    if (wd == TO_W'(TIMEOUT - 1)) begin
                        err_d   = ERR_TO;
                        state_d = S_ABORT;
                    end
                end
            end
            S_ABORT: state_d = S_DRAIN;
            S_DRAIN: begin
                if (cu_ready) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign busy        = (state != S_IDLE);
    assign done        = (state == S_DONE);
    assign cu_clear    = (state == S_ABORT);
    assign cu_en       = (state == S_ISSUE) && cu_ready && !abort;
    assign cu_op       = ir[OP_LSB +: OP_W];
    assign cu_opt_mod  = ir[MOD_B];
    assign cu_opt_accx = ir[ACCX_B];
    assign cu_opt_accy = ir[ACCY_B];

    assign ir_rsvd_unused = ir[RSVD_B];

endmodule
